// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared encodings for the 16-bit CPU control path: controller state codes,
// opcode map, ALU operation codes, PC source selects and the coarse
// instruction class produced by alu_op_decode.
package cpu_ctrl_pkg;

    // Controller states (3-bit, codes 6-7 are illegal and recover to IF)
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EXE  = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    // Opcodes, IR[15:12]
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_SLTU = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_ORI  = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_BLTZ = 4'hD;
    localparam logic [3:0] OP_J    = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SLL   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_SLTU  = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    // PC source selects
    localparam logic [1:0] PC_PLUS1  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_MEM    = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_JUMP   = 3'd3,
        CLS_HALT   = 3'd4
    } insn_class_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Purely combinational opcode decoder shared with the single-cycle datapath.
// Ports:
//   i_op        in  4  opcode
//   o_alu_op    out 3  ALU operation for the execute step
//   o_alu_src_b out 1  0 = register B, 1 = sign-extended immediate
//   o_class     out 3  instruction class (alu/mem/branch/jump/halt)
import cpu_ctrl_pkg::*;

module alu_op_decode (
    input  logic [3:0]  i_op,
    output logic [2:0]  o_alu_op,
    output logic        o_alu_src_b,
    output insn_class_t o_class
);

    always_comb begin
        o_alu_op    = ALU_ADD;
        o_alu_src_b = 1'b0;
        o_class     = CLS_ALU;
        case (i_op)
            OP_ADD, OP_SUB, OP_SLL, OP_OR, OP_AND, OP_SLTU, OP_SLT: begin
                // R-type: the low opcode bits are the ALU code directly
                o_alu_op = i_op[2:0];
            end
            OP_ADDI: begin
                o_alu_op    = ALU_ADD;
                o_alu_src_b = 1'b1;
            end
            OP_ORI: begin
                o_alu_op    = ALU_OR;
                o_alu_src_b = 1'b1;
            end
            OP_LW, OP_SW: begin
                o_alu_op    = ALU_ADD;
                o_alu_src_b = 1'b1;
                o_class     = CLS_MEM;
            end
            OP_BEQ, OP_BNE, OP_BLTZ: begin
                // BLTZ compares rs - $0, so its sign flag is rs[15]
                o_alu_op = ALU_SUB;
                o_class  = CLS_BRANCH;
            end
            OP_J:    o_class = CLS_JUMP;
            default: o_class = CLS_HALT;
        endcase
    end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// cpu_multicycle_ctrl
// Multi-cycle control unit: IF -> ID -> EXE -> (MEM) -> (WB), plus HALT.
// All strobes are combinational from the current state, the latched opcode,
// mem_ready and the ALU flags; reset forces every output to its idle value.
// Ports:
//   clk, rst (sync, active-high)
//   op, zero, sign, mem_ready            inputs from IR / ALU / memory
//   ALUopcode, alu_src_b                 ALU control
//   ir_write, pc_write, pc_src           fetch / PC control
//   mem_read, mem_write                  memory strobes
//   reg_write, reg_dst, mem_to_reg       register-file write-back control
//   state, halted                        debug / status
//   retired                              retired-instruction count
// Build option: CTRL_INSN_COUNT_EN builds the 16-bit retire counter;
// without it `retired` is tied to zero.
import cpu_ctrl_pkg::*;

module cpu_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic        zero,
    input  logic        sign,
    input  logic        mem_ready,
    output logic [2:0]  ALUopcode,
    output logic        alu_src_b,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [2:0]  state,
    output logic        halted,
    output logic [15:0] retired
);

    logic [2:0]  r_state;
    logic [3:0]  r_op_q;

    logic [2:0]  w_next;
    logic [2:0]  w_alu_q;
    logic        w_srcb_q;
    insn_class_t w_cls_q;

    logic [2:0]  w_alu_op;
    logic        w_alu_src_b;
    logic        w_ir_write;
    logic        w_pc_write;
    logic [1:0]  w_pc_src;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_reg_write;
    logic        w_reg_dst;
    logic        w_mem_to_reg;
    logic        w_halted;

    alu_op_decode u_dec (
        .i_op        (r_op_q),
        .o_alu_op    (w_alu_q),
        .o_alu_src_b (w_srcb_q),
        .o_class     (w_cls_q)
    );

    always_comb begin
        w_next       = r_state;
        w_alu_op     = ALU_ADD;
        w_alu_src_b  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = PC_PLUS1;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            S_IF: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_ID;
                end
            end
            S_ID: begin
                // op_q is only loaded at the end of ID, so decide from live op
                if (op == OP_J) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = PC_JUMP;
                    w_next     = S_IF;
                end else if (op == OP_HALT) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                w_alu_op    = w_alu_q;
                w_alu_src_b = w_srcb_q;
                case (w_cls_q)
                    CLS_ALU: w_next = S_WB;
                    CLS_MEM: w_next = S_MEM;
                    CLS_BRANCH: begin
                        w_pc_src = PC_BRANCH;
                        case (r_op_q)
                            OP_BEQ:  w_pc_write = zero;
                            OP_BNE:  w_pc_write = ~zero;
                            default: w_pc_write = sign;
                        endcase
                        w_next = S_IF;
                    end
                    default: w_next = S_IF;
                endcase
            end
            S_MEM: begin
                w_mem_read  = (r_op_q == OP_LW);
                w_mem_write = (r_op_q != OP_LW);
                if (mem_ready) w_next = (r_op_q == OP_LW) ? S_WB : S_IF;
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = (r_op_q < OP_ADDI);
                w_mem_to_reg = (r_op_q == OP_LW);
                w_next       = S_IF;
            end
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_op_q  <= 4'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) r_op_q <= op;
        end
    end

    // Reset masks every output so an aborted access never strobes
    assign ALUopcode  = rst ? ALU_ADD  : w_alu_op;
    assign alu_src_b  = rst ? 1'b0     : w_alu_src_b;
    assign ir_write   = rst ? 1'b0     : w_ir_write;
    assign pc_write   = rst ? 1'b0     : w_pc_write;
    assign pc_src     = rst ? PC_PLUS1 : w_pc_src;
    assign mem_read   = rst ? 1'b0     : w_mem_read;
    assign mem_write  = rst ? 1'b0     : w_mem_write;
    assign reg_write  = rst ? 1'b0     : w_reg_write;
    assign reg_dst    = rst ? 1'b0     : w_reg_dst;
    assign mem_to_reg = rst ? 1'b0     : w_mem_to_reg;
    assign halted     = rst ? 1'b0     : w_halted;
    assign state      = rst ? S_IF     : r_state;

`ifdef CTRL_INSN_COUNT_EN
    logic [15:0] r_retired;
    logic        w_retire;

    // An instruction retires on any edge from ID..WB back to IF or into HALT
    assign w_retire = (r_state inside {S_ID, S_EXE, S_MEM, S_WB}) &&
                      (w_next == S_IF || w_next == S_HALT);

    always_ff @(posedge clk) begin
        if (rst)           r_retired <= 16'd0;
        else if (w_retire) r_retired <= r_retired + 16'd1;
    end

    assign retired = r_retired;
`else
    assign retired = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Self-checking bench for cpu_multicycle_ctrl. Each instruction is expanded
// into its expected per-cycle output schedule; a negedge process compares
// the DUT against the current schedule entry every cycle.
module tb_cpu_multicycle_ctrl;

`ifdef CTRL_INSN_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic        clk, rst, zero, sign, mem_ready;
    logic [3:0]  op;
    logic [2:0]  ALUopcode, state;
    logic [1:0]  pc_src;
    logic        alu_src_b, ir_write, pc_write, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, halted;
    logic [15:0] retired;

    cpu_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .sign(sign),
        .mem_ready(mem_ready), .ALUopcode(ALUopcode), .alu_src_b(alu_src_b),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .halted(halted), .retired(retired)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] alu;
        logic       srcb, irw, pcw;
        logic [1:0] pcs;
        logic       mr, mw, rw, rd, m2r, hlt;
    } exp_t;

    exp_t        exp_cur, act;
    logic        exp_v = 1'b0;
    string       cur_nm = "";
    logic [15:0] m_ret = 16'd0;
    int          n_checks = 0, n_fail = 0, cyc_cnt = 0;

    initial clk = 1'b1;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_v) begin
            act = {state, ALUopcode, alu_src_b, ir_write, pc_write, pc_src,
                   mem_read, mem_write, reg_write, reg_dst, mem_to_reg, halted};
            n_checks++;
            if (act !== exp_cur) begin
                n_fail++;
                $display("FAIL %s: outputs got %h expected %h", cur_nm, act, exp_cur);
            end
            n_checks++;
            if (retired !== m_ret) begin
                n_fail++;
                $display("FAIL %s_retired: got %h expected %h", cur_nm, retired, m_ret);
            end
        end
    end

    function automatic logic [2:0] alu_of(input logic [3:0] o);
        if (o <= 4'd6) return o[2:0];
        case (o)
            4'd8:              return 3'b011;
            4'd11, 4'd12, 4'd13: return 3'b001;
            default:           return 3'b000;
        endcase
    endfunction

    task automatic chk(input string nm, input int a, input int e);
        n_checks++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic rnd();
        op        = 4'($urandom);
        zero      = 1'($urandom);
        sign      = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    // One clock: publish expectation, let the edge happen, update the model
    task automatic step(input exp_t e, input bit ret, input string nm);
        exp_cur = e;
        cur_nm  = nm;
        exp_v   = 1'b1;
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (rst) m_ret = 16'd0;
        else if (ret && COUNT_EN) m_ret = m_ret + 16'd1;
    endtask

    task automatic run_insn(input logic [3:0] o, input int if_st, input int mem_st,
                            input logic z, input logic s, input bit rst_mem);
        exp_t e;
        cyc_cnt = 0;
        for (int k = 0; k < if_st; k++) begin
            rnd(); mem_ready = 1'b0;
            e = '0; e.mr = 1'b1;
            step(e, 1'b0, "if_stall");
        end
        rnd(); mem_ready = 1'b1;
        e = '0; e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        step(e, 1'b0, "if");
        rnd(); op = o;
        e = '0; e.st = 3'd1;
        if (o == 4'hE) begin e.pcw = 1'b1; e.pcs = 2'b10; end
        step(e, o >= 4'hE, "id");
        if (o >= 4'hE) return;
        rnd(); zero = z; sign = s;
        e = '0; e.st = 3'd2; e.alu = alu_of(o);
        e.srcb = (o >= 4'd7 && o <= 4'd10);
        if (o >= 4'hB) begin
            e.pcs = 2'b01;
            e.pcw = (o == 4'hB) ? z : (o == 4'hC) ? ~z : s;
            step(e, 1'b1, "exe_br");
            return;
        end
        step(e, 1'b0, "exe");
        if (o == 4'h9 || o == 4'hA) begin
            if (rst_mem) begin
                rnd(); rst = 1'b1;
                e = '0;
                step(e, 1'b0, "rst_in_mem");
                rst = 1'b0;
                return;
            end
            e = '0; e.st = 3'd3; e.mr = (o == 4'h9); e.mw = (o == 4'hA);
            for (int k = 0; k < mem_st; k++) begin
                rnd(); mem_ready = 1'b0;
                step(e, 1'b0, "mem_stall");
            end
            rnd(); mem_ready = 1'b1;
            step(e, o == 4'hA, "mem");
            if (o == 4'hA) return;
        end
        rnd();
        e = '0; e.st = 3'd4; e.rw = 1'b1; e.rd = (o <= 4'd6); e.m2r = (o == 4'h9);
        step(e, 1'b1, "wb");
    endtask

    initial begin
        exp_t e0;
        e0 = '0;
        rst = 1'b1;
        rnd();
        for (int k = 0; k < 3; k++) begin
            rnd();
            step(e0, 1'b0, "reset");
        end
        rst = 1'b0;

        run_insn(4'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("add_cycles", cyc_cnt, 4);
        chk("add_retired", int'(retired), COUNT_EN ? 1 : 0);
        run_insn(4'h9, 0, 2, 1'b0, 1'b0, 1'b0);
        chk("lw_stall_cycles", cyc_cnt, 7);
        run_insn(4'hB, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("beq_cycles", cyc_cnt, 3);
        run_insn(4'hC, 0, 0, 1'b1, 1'b0, 1'b0);
        run_insn(4'hE, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("j_cycles", cyc_cnt, 2);
        run_insn(4'hA, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("sw_cycles", cyc_cnt, 4);
        run_insn(4'hD, 1, 0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++)
            run_insn(4'($urandom_range(0, 14)), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1'($urandom), 1'($urandom), 1'b0);

        run_insn(4'hA, 0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_mem_state", int'(state), 0);
        run_insn(4'h7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_insn(4'h8, 2, 0, 1'b0, 1'b0, 1'b0);

        run_insn(4'hF, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            exp_t eh;
            rnd();
            eh = '0; eh.st = 3'd5; eh.hlt = 1'b1;
            step(eh, 1'b0, "halt");
        end
        chk("halt_held", int'(halted), 1);
        rnd(); rst = 1'b1;
        step(e0, 1'b0, "halt_rst");
        rst = 1'b0;
        chk("halt_exit_state", int'(state), 0);
        run_insn(4'h3, 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef CTRL_INSN_COUNT_EN
        // Preload the counter to its top value while stalled in IF
        exp_v = 1'b0;
        mem_ready = 1'b0;
        force dut.r_retired = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_retired;
        m_ret = 16'hFFFF;
        run_insn(4'hE, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("retired_wrap", int'(retired), 0);
`endif

        exp_v = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle_ctrl.md
# cpu_multicycle_ctrl

Multi-cycle control unit for the 16-bit CPU. It sequences each instruction through fetch, decode, execute, memory and write-back. In every state it drives the ALU operation code and operand selects, and it takes the ALU `zero`/`sign` flags back to resolve branches. It also owns the register-file, memory, IR and PC write strobes, and stalls on a memory ready handshake.

## Interface
Parameters:
- none (encodings fixed in package)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `op`  in  4  instruction opcode, IR[15:12]; valid from ID onward
- `zero`  in  1  ALU zero flag (result == 0)
- `sign`  in  1  ALU sign flag (result[15])
- `mem_ready`  in  1  memory completes current access this cycle
- `ALUopcode`  out  3  ALU operation (000 add, 001 sub, 010 sll, 011 or, 100 and, 101 sltu, 110 slt, 111 passb)
- `alu_src_b`  out  1  0 = register B, 1 = sign-extended imm
- `ir_write`  out  1  load IR
- `pc_write`  out  1  load PC
- `pc_src`  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `reg_write`  out  1  register-file write
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  write-back from memory
- `state`  out  3  current state, for debug
- `halted`  out  1  in HALT
- `retired`  out  16  retired-instruction count (see Configuration)

## Operation
- Opcode map: 0–6 R-type with ALUopcode = op[2:0]; 7 ADDI (000, imm); 8 ORI (011, imm); 9 LW; A SW (000, imm); B BEQ; C BNE; D BLTZ (001, reg B; the ISA encodes rt = $0 for BLTZ); E J; F HALT.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Encodings 6–7 are illegal and go to IF.
- IF:
  - `mem_read`=1.
  - When `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to ID. Otherwise hold in IF.
- ID: latch `op` into `op_q`. Next state:
  - J: `pc_write`=1, `pc_src`=10, go to IF.
  - HALT: go to HALT.
  - otherwise: go to EXE.
- EXE: drive ALUopcode and `alu_src_b` from `op_q`. Next state:
  - ALU ops: WB.
  - LW/SW: MEM.
  - Branches: `pc_src`=01, go to IF, with `pc_write` set by the branch condition:
    - BEQ: `zero`
    - BNE: `!zero`
    - BLTZ: `sign`
- MEM: `mem_read` (LW) or `mem_write` (SW) is held while waiting.
  - When `mem_ready`: LW goes to WB; SW goes to IF.
  - Otherwise hold.
- WB: `reg_write`=1, go to IF.
  - `reg_dst`=1 for R-type only.
  - `mem_to_reg`=1 for LW only.
- HALT:
  - All strobes 0; `halted`=1.
  - Exits only on `rst`.
- Strobes are combinational from (`state`, `op_q`, `mem_ready`, `zero`, `sign`). In states where a strobe is not listed, it is 0. ALUopcode defaults to 000.

## Timing
- Reset:
  - `state`=IF, `op_q`=0, `retired`=0.
  - While `rst`=1, every strobe output is forced 0, ALUopcode=000, `pc_src`=00, `halted`=0.
- Reset mid-instruction aborts it with no write. The first cycle after deassertion is IF.
- Cycle counts with `mem_ready` tied 1:
  - J: 2
  - branch: 3
  - R-type/ADDI/ORI/SW: 4
  - LW: 5
- Each IF or MEM cycle with `mem_ready`=0 adds one cycle.
- Branch flags are sampled in the same EXE cycle. There is no flag register.
- `mem_ready` is ignored outside IF/MEM.

## Configuration
- `CTRL_INSN_COUNT_EN` defined: `retired` increments by 1, wrapping at 16'hFFFF→0, on each retire edge. Retire edges are:
  - WB→IF
  - MEM→IF (SW)
  - EXE→IF (branch, taken or not)
  - ID→IF (J)
  - ID→HALT
- `CTRL_INSN_COUNT_EN` undefined: `retired` is constant 0 and no counter flops are built.

## Structure
- Package `cpu_ctrl_pkg`: state encodings, opcode constants (OP_ADD…OP_HALT), ALU op constants (ALU_ADD…ALU_PASSB), `pc_src` codes.
- Sub-module `alu_op_decode`: combinational `op_q` → {ALUopcode, `alu_src_b`, class (alu/mem/branch/jump/halt)}. It is reused by the single-cycle datapath.

## Test plan
- Reset held 3 cycles, then released: `state`=0 and all strobes 0 during reset; IF with `mem_read`=1 on the first free cycle.
- ADD (op 0), `mem_ready`=1: states IF,ID,EXE,WB. `ALUopcode`=000 in EXE; `reg_write`=1 and `reg_dst`=1 in WB; `retired` 0→1.
- LW with `mem_ready` low 2 cycles in MEM: 7 cycles total. `mem_read` held through the stall; WB has `mem_to_reg`=1.
- BEQ with `zero`=1, then BNE with `zero`=1: BEQ gives `pc_write`=1, `pc_src`=01 in EXE. BNE gives `pc_write`=0 and returns to IF.
- HALT (op F): `halted`=1 from the cycle after ID and stays 1 for 20 cycles with all strobes 0. `rst` returns to IF.
- `rst` asserted in MEM of SW: no `mem_write` in the reset cycle, next state IF. With `CTRL_INSN_COUNT_EN`, `retired` wraps 16'hFFFF→0 on the next retire.
